// File: rtl/fft32_core.sv
// 32-point radix-2 DIT FFT/IFFT: serial load, in-place butterflies, serial natural-order output.
// Optional build macro FFT32_SCALE_EN halves every butterfly result (output = DFT/32).
module fft32_core #(
   parameter int total_bits = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  ED,
   input  logic                  START,
   input  logic [total_bits-1:0] DReal,
   input  logic [total_bits-1:0] DImag,
   input  logic                  ifft,
   output logic                  RDY,
   output logic [total_bits-1:0] DOReal,
   output logic [total_bits-1:0] DOImag,
   output logic [1:0]            o_dbg_state
);

   // Handshake: ED is a global enable (nothing moves while ED=0); there is no
   // back-pressure. RDY marks the single ED cycle carrying bin 0, bins 1..31 follow
   // on consecutive ED cycles. START (any ED) aborts and begins a new frame.

   localparam int PW = total_bits + 17;
   localparam int SW = PW + 1;

   typedef logic signed [total_bits-1:0] smp_t;
   typedef logic signed [PW-1:0]         prod_t;
   typedef logic signed [SW-1:0]         sum_t;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CALC = 2'd2, S_OUT = 2'd3} state_t;

   state_t     r_state;
   logic [4:0] r_cnt;
   logic [2:0] r_stage;
   logic [3:0] r_bfly;
   logic       r_inv;
   logic       r_rdy;
   smp_t       r_dor;
   smp_t       r_doi;
   smp_t       r_mem_re [0:31];
   smp_t       r_mem_im [0:31];

   logic [3:0]         w_mask;
   logic [3:0]         w_j;
   logic [3:0]         w_k;
   logic [4:0]         w_h;
   logic [4:0]         w_a;
   logic [4:0]         w_b;
   logic signed [15:0] w_wr;
   logic signed [15:0] w_sin;
   logic signed [15:0] w_wi;
   smp_t               w_ar, w_ai, w_br, w_bi;
   prod_t              w_pr, w_pi, w_tr, w_ti;
   sum_t               w_sa_re, w_sa_im, w_sb_re, w_sb_im;
   smp_t               w_na_re, w_na_im, w_nb_re, w_nb_im;
   logic               w_adv;

   function automatic logic [4:0] rev5(input logic [4:0] v);
      return {v[0], v[1], v[2], v[3], v[4]};
   endfunction

   assign w_adv = ED && !RST && !START;

   // Butterfly addressing: span h=2^s, j=m mod h, a=(m/h)*2h+j, b=a+h, k=j*(16>>s).
   always_comb begin
      w_h    = 5'd1 << r_stage;
      w_mask = 4'(w_h - 5'd1);
      w_j    = r_bfly & w_mask;
      w_a    = 5'(({1'b0, r_bfly} >> r_stage) << (r_stage + 3'd1)) | {1'b0, w_j};
      w_b    = w_a + w_h;
      w_k    = w_j << (3'd4 - r_stage);
   end

   always_comb begin
      w_wr  = 16'sd16384;
      w_sin = 16'sd0;
      case (w_k)
         4'd0:  begin w_wr = 16'sd16384;  w_sin = 16'sd0;     end
         4'd1:  begin w_wr = 16'sd16069;  w_sin = 16'sd3196;  end
         4'd2:  begin w_wr = 16'sd15137;  w_sin = 16'sd6270;  end
         4'd3:  begin w_wr = 16'sd13623;  w_sin = 16'sd9102;  end
         4'd4:  begin w_wr = 16'sd11585;  w_sin = 16'sd11585; end
         4'd5:  begin w_wr = 16'sd9102;   w_sin = 16'sd13623; end
         4'd6:  begin w_wr = 16'sd6270;   w_sin = 16'sd15137; end
         4'd7:  begin w_wr = 16'sd3196;   w_sin = 16'sd16069; end
         4'd8:  begin w_wr = 16'sd0;      w_sin = 16'sd16384; end
         4'd9:  begin w_wr = -16'sd3196;  w_sin = 16'sd16069; end
         4'd10: begin w_wr = -16'sd6270;  w_sin = 16'sd15137; end
         4'd11: begin w_wr = -16'sd9102;  w_sin = 16'sd13623; end
         4'd12: begin w_wr = -16'sd11585; w_sin = 16'sd11585; end
         4'd13: begin w_wr = -16'sd13623; w_sin = 16'sd9102;  end
         4'd14: begin w_wr = -16'sd15137; w_sin = 16'sd6270;  end
         default: begin w_wr = -16'sd16069; w_sin = 16'sd3196; end
      endcase
      // Forward uses e^-j, so the imaginary twiddle is -sin; inverse conjugates it.
      w_wi = r_inv ? w_sin : -w_sin;
   end

   always_comb begin
      w_ar = r_mem_re[w_a];
      w_ai = r_mem_im[w_a];
      w_br = r_mem_re[w_b];
      w_bi = r_mem_im[w_b];
      w_pr = prod_t'(w_br) * prod_t'(w_wr) - prod_t'(w_bi) * prod_t'(w_wi);
      w_pi = prod_t'(w_br) * prod_t'(w_wi) + prod_t'(w_bi) * prod_t'(w_wr);
      w_tr = w_pr >>> 14;
      w_ti = w_pi >>> 14;
      w_sa_re = sum_t'(w_ar) + sum_t'(w_tr);
      w_sa_im = sum_t'(w_ai) + sum_t'(w_ti);
      w_sb_re = sum_t'(w_ar) - sum_t'(w_tr);
      w_sb_im = sum_t'(w_ai) - sum_t'(w_ti);
`ifdef FFT32_SCALE_EN
      w_na_re = smp_t'(w_sa_re >>> 1);
      w_na_im = smp_t'(w_sa_im >>> 1);
      w_nb_re = smp_t'(w_sb_re >>> 1);
      w_nb_im = smp_t'(w_sb_im >>> 1);
`else
      w_na_re = smp_t'(w_sa_re);
      w_na_im = smp_t'(w_sa_im);
      w_nb_re = smp_t'(w_sb_re);
      w_nb_im = smp_t'(w_sb_im);
`endif
   end

   // Sample store: bit-reversed writes during load, two in-place writes per butterfly.
   always_ff @(posedge CLK) begin
      if (w_adv) begin
         if (r_state == S_LOAD) begin
            r_mem_re[rev5(r_cnt)] <= DReal;
            r_mem_im[rev5(r_cnt)] <= DImag;
         end else if (r_state == S_CALC) begin
            r_mem_re[w_a] <= w_na_re;
            r_mem_im[w_a] <= w_na_im;
            r_mem_re[w_b] <= w_nb_re;
            r_mem_im[w_b] <= w_nb_im;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
         r_cnt   <= 5'd0;
         r_stage <= 3'd0;
         r_bfly  <= 4'd0;
         r_inv   <= 1'b0;
         r_rdy   <= 1'b0;
         r_dor   <= '0;
         r_doi   <= '0;
      end else if (START) begin
         r_state <= S_LOAD;
         r_cnt   <= 5'd0;
         r_stage <= 3'd0;
         r_bfly  <= 4'd0;
         r_inv   <= ifft;
         r_rdy   <= 1'b0;
      end else if (ED) begin
         r_rdy <= 1'b0;
         case (r_state)
            S_LOAD: begin
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  r_state <= S_CALC;
                  r_stage <= 3'd0;
                  r_bfly  <= 4'd0;
               end
            end
            S_CALC: begin
               r_bfly <= r_bfly + 4'd1;
               if (r_bfly == 4'd15) begin
                  if (r_stage == 3'd4) begin
                     r_state <= S_OUT;
                     r_cnt   <= 5'd0;
                     r_stage <= 3'd0;
                  end else begin
                     r_stage <= r_stage + 3'd1;
                  end
               end
            end
            S_OUT: begin
               r_rdy <= (r_cnt == 5'd0);
               r_dor <= r_mem_re[r_cnt];
               r_doi <= r_mem_im[r_cnt];
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign RDY         = r_rdy;
   assign DOReal      = r_dor;
   assign DOImag      = r_doi;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fft32_core.sv
// Directed bench for fft32_core: a loop-level fixed-point FFT model checked every output
// cycle, plus literal bin values for impulse/DC/shifted-impulse frames.
module tb_fft32_core;

   localparam real PI = 3.14159265358979323846;

   logic        CLK = 1'b0;
   logic        RST, ED, START, ifft;
   logic [31:0] DReal, DImag;
   logic        RDY;
   logic [31:0] DOReal, DOImag;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;
   int frames_done = 0;

   int x_re[32], x_im[32];
   int exp_re[32], exp_im[32];
   int got_re[32], got_im[32];

   bit   frame_active = 1'b0;
   int   ed_cnt = 0;
   int   last_re = 0, last_im = 0;
   logic last_rdy = 1'b0;
   logic s_ed, s_st, s_rs;
   int   bin;

   fft32_core #(.total_bits(32)) dut (
      .CLK(CLK), .RST(RST), .ED(ED), .START(START),
      .DReal(DReal), .DImag(DImag), .ifft(ifft),
      .RDY(RDY), .DOReal(DOReal), .DOImag(DOImag),
      .o_dbg_state(dbg_state)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input longint act, input longint expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic int rnd(input real r);
      if (r >= 0.0) return $rtoi(r + 0.5);
      return -$rtoi(-r + 0.5);
   endfunction

   function automatic int tw_c(input int k);
      return rnd(16384.0 * $cos(2.0 * PI * k / 32.0));
   endfunction

   function automatic int tw_s(input int k);
      return rnd(16384.0 * $sin(2.0 * PI * k / 32.0));
   endfunction

   function automatic int rev(input int n);
      int r = 0;
      for (int i = 0; i < 5; i++) if (((n >> i) & 1) != 0) r |= (1 << (4 - i));
      return r;
   endfunction

   // Textbook in-place DIT on bit-reversed data with the fixed-point butterfly rules.
   function automatic void fft_model(input bit inv);
      int re[32], im[32];
      for (int n = 0; n < 32; n++) begin
         re[rev(n)] = x_re[n];
         im[rev(n)] = x_im[n];
      end
      for (int s = 0; s < 5; s++) begin
         for (int m = 0; m < 16; m++) begin
            int h, j, a, b, k;
            longint wr, wi, tr, ti, sar, sai, sbr, sbi;
            h  = 1 << s;
            j  = m % h;
            a  = (m / h) * 2 * h + j;
            b  = a + h;
            k  = j * (16 >> s);
            wr = tw_c(k);
            wi = inv ? tw_s(k) : -tw_s(k);
            tr = (longint'(re[b]) * wr - longint'(im[b]) * wi) >>> 14;
            ti = (longint'(re[b]) * wi + longint'(im[b]) * wr) >>> 14;
            sar = longint'(re[a]) + tr;
            sai = longint'(im[a]) + ti;
            sbr = longint'(re[a]) - tr;
            sbi = longint'(im[a]) - ti;
`ifdef FFT32_SCALE_EN
            sar = sar >>> 1; sai = sai >>> 1; sbr = sbr >>> 1; sbi = sbi >>> 1;
`endif
            re[a] = int'(sar); im[a] = int'(sai);
            re[b] = int'(sbr); im[b] = int'(sbi);
         end
      end
      for (int n = 0; n < 32; n++) begin
         exp_re[n] = re[n];
         exp_im[n] = im[n];
      end
   endfunction

   task automatic set_impulse(input int idx, input int val);
      for (int n = 0; n < 32; n++) begin
         x_re[n] = (n == idx) ? val : 0;
         x_im[n] = 0;
      end
   endtask

   task automatic set_dc(input int val);
      for (int n = 0; n < 32; n++) begin
         x_re[n] = val;
         x_im[n] = 0;
      end
   endtask

   // START, then n_ed enabled cycles (first 32 carry samples), with optional ED gaps.
   task automatic run_frame(input bit inv, input int gap_pct, input int n_ed, input bit start_ed);
      fft_model(inv);
      @(negedge CLK);
      START = 1'b1; ED = start_ed; ifft = inv;
      DReal = 32'h1234_5678; DImag = 32'h8765_4321;
      for (int c = 0; c < n_ed; c++) begin
         int gaps = 0;
         @(negedge CLK);
         START = 1'b0;
         ifft  = ~inv;
         while (gap_pct > 0 && gaps < 3 && $urandom_range(99, 0) < gap_pct) begin
            ED = 1'b0; DReal = $urandom; DImag = $urandom;
            gaps++;
            @(negedge CLK);
         end
         ED = 1'b1;
         if (c < 32) begin
            DReal = x_re[c]; DImag = x_im[c];
         end else begin
            DReal = $urandom; DImag = $urandom;
         end
      end
      @(negedge CLK);
      ED = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         ED = ($urandom_range(3, 0) != 0);
      end
   endtask

   // Compare process: timing of RDY and every output bin against the model.
   always @(posedge CLK) begin
      s_ed = ED; s_st = START; s_rs = RST;
      #1;
      if (s_rs) begin
         frame_active = 1'b0;
         chk("reset_rdy", RDY, 0);
         chk("reset_doreal", $signed(DOReal), 0);
         chk("reset_doimag", $signed(DOImag), 0);
      end else if (s_st) begin
         frame_active = 1'b1;
         ed_cnt = 0;
      end else if (frame_active) begin
         if (s_ed) begin
            ed_cnt++;
            if (ed_cnt <= 112) begin
               chk("rdy_before_113", RDY, 0);
            end else begin
               bin = ed_cnt - 113;
               chk($sformatf("rdy_bin%0d", bin), RDY, (bin == 0) ? 1 : 0);
               chk($sformatf("bin%0d_re", bin), $signed(DOReal), exp_re[bin]);
               chk($sformatf("bin%0d_im", bin), $signed(DOImag), exp_im[bin]);
               got_re[bin] = $signed(DOReal);
               got_im[bin] = $signed(DOImag);
               if (bin == 31) begin
                  frame_active = 1'b0;
                  frames_done++;
               end
            end
         end else if (ed_cnt >= 113) begin
            chk("stall_rdy_hold", RDY, last_rdy);
            chk("stall_re_hold", $signed(DOReal), last_re);
            chk("stall_im_hold", $signed(DOImag), last_im);
         end
      end else begin
         chk("idle_rdy", RDY, 0);
         chk("idle_re_hold", $signed(DOReal), last_re);
         chk("idle_im_hold", $signed(DOImag), last_im);
      end
      last_rdy = RDY;
      last_re  = $signed(DOReal);
      last_im  = $signed(DOImag);
   end

   initial begin
      // Reset with START asserted: RST must win, so the core stays idle afterwards.
      RST = 1'b1; START = 1'b1; ED = 1'b1; ifft = 1'b0;
      DReal = 32'd5; DImag = 32'd7;
      repeat (3) @(negedge CLK);
      RST = 1'b0; START = 1'b0;
      idle(150);

      // Model pinned by hand: forward twiddle k=1 and k=8.
      chk("model_tw1_re", tw_c(1), 16069);
      chk("model_tw1_sin", tw_s(1), 3196);
      chk("model_tw8_re", tw_c(8), 0);

      set_impulse(0, 1000);
      run_frame(1'b0, 0, 144, 1'b1);
      chk("imp_x0_re", got_re[0], 1000);
      chk("imp_x17_re", got_re[17], 1000);
      chk("imp_x31_re", got_re[31], 1000);
      chk("imp_x31_im", got_im[31], 0);
      idle(5);

      set_dc(100);
      run_frame(1'b0, 0, 144, 1'b1);
      chk("dc_x0_re", got_re[0], 3200);
      chk("dc_x0_im", got_im[0], 0);
      chk("dc_x5_re", got_re[5], 0);
      chk("dc_x31_re", got_re[31], 0);

      set_dc(100);
      fft_model(1'b0);
      chk("model_dc_x0", exp_re[0], 3200);
      for (int n = 0; n < 32; n++) begin
         x_re[n] = got_re[n];
         x_im[n] = got_im[n];
      end
      run_frame(1'b1, 0, 144, 1'b1);
      chk("fwd_inv_x0_re", got_re[0], 3200);
      chk("fwd_inv_x13_re", got_re[13], 3200);
      chk("fwd_inv_x13_im", got_im[13], 0);

      set_impulse(1, 16384);
      run_frame(1'b0, 0, 144, 1'b1);
      chk("shift_x0_re", got_re[0], 16384);
      chk("shift_x1_re", got_re[1], 16069);
      chk("shift_x1_im", got_im[1], -3196);
      chk("shift_x8_re", got_re[8], 0);
      chk("shift_x8_im", got_im[8], -16384);
      chk("shift_x16_re", got_re[16], -16384);
      chk("shift_x24_im", got_im[24], 16384);

      run_frame(1'b1, 0, 144, 1'b0);
      chk("ishift_x1_im", got_im[1], 3196);
      chk("ishift_x8_im", got_im[8], 16384);
      chk("ishift_x24_im", got_im[24], -16384);
      idle(4);

      // Large wrapping data, ungated then heavily gated.
      for (int n = 0; n < 32; n++) begin
         x_re[n] = n * 32'sh0913_5A7B;
         x_im[n] = 32'sh7000_0000 - n * 1000003;
      end
      run_frame(1'b0, 0, 144, 1'b1);
      run_frame(1'b0, 40, 144, 1'b0);
      idle(3);

      // Reset mid-CALC, with START and ED high in the reset cycle.
      set_impulse(0, 1000);
      run_frame(1'b0, 0, 60, 1'b1);
      RST = 1'b1; START = 1'b1; ED = 1'b1;
      @(negedge CLK);
      RST = 1'b0; START = 1'b0;
      idle(130);
      set_impulse(0, -777);
      run_frame(1'b0, 20, 144, 1'b1);
      chk("post_rst_x9_re", got_re[9], -777);

      // START mid-OUT restarts cleanly.
      set_impulse(1, 16384);
      run_frame(1'b1, 0, 120, 1'b1);
      set_dc(100);
      run_frame(1'b0, 0, 144, 1'b1);
      chk("restart_dc_x0_re", got_re[0], 3200);
      chk("restart_dc_x8_im", got_im[8], 0);
      idle(10);

      chk("frames_done", frames_done, 9);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
